// File: rtl/crypto_seq_arbiter.sv
// crypto_seq_arbiter: round-robin arbiter for two crypto job requesters.
// A granted job runs for ROUNDS cycles through the combinational crypto
// datapath. Each result is fed back as the next round's data. A one-cycle
// response then goes to the port that owns the job.
module crypto_seq_arbiter #(
   parameter int unsigned ROUNDS = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ0_VALID,
   input  logic [31:0] REQ0_DATA,
   input  logic [31:0] REQ0_KEY,
   input  logic        REQ0_SEL,
   output logic        REQ0_READY,
   output logic        RSP0_VALID,
   output logic [31:0] RSP0_DATA,
   input  logic        REQ1_VALID,
   input  logic [31:0] REQ1_DATA,
   input  logic [31:0] REQ1_KEY,
   input  logic        REQ1_SEL,
   output logic        REQ1_READY,
   output logic        RSP1_VALID,
   output logic [31:0] RSP1_DATA,
   output logic [31:0] CM_DATA_IN,
   output logic [31:0] CM_KEY,
   output logic [1:0]  CM_CNT,
   output logic        CM_SEL,
   input  logic [31:0] CM_RESULT,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

   state_t      state_q, state_d;
   logic [31:0] st_q, st_d;
   logic [31:0] key_q, key_d;
   logic        sel_q, sel_d;
   logic [3:0]  round_q, round_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic        grant0, grant1;

   // Only the datapath data, key and mode come from registers. CM_CNT is decoded from the state.
   assign CM_DATA_IN = st_q;
   assign CM_KEY     = key_q;
   assign CM_SEL     = sel_q;

   // Port 0 wins when it is alone, or on a tie when port 1 was granted last.
   assign grant0 = (state_q == IDLE) && REQ0_VALID && (!REQ1_VALID || last_grant_q);
   assign grant1 = (state_q == IDLE) && REQ1_VALID && (!REQ0_VALID || !last_grant_q);

   // State and job registers. Reset takes priority and aborts any job in flight.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= IDLE;
         st_q         <= '0;
         key_q        <= '0;
         sel_q        <= 1'b0;
         round_q      <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         st_q         <= st_d;
         key_q        <= key_d;
         sel_q        <= sel_d;
         round_q      <= round_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state logic and the outputs decoded from the state.
   always_comb begin
      state_d      = state_q;
      st_d         = st_q;
      key_d        = key_q;
      sel_d        = sel_q;
      round_d      = round_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      REQ0_READY   = 1'b0;
      REQ1_READY   = 1'b0;
      RSP0_VALID   = 1'b0;
      RSP0_DATA    = '0;
      RSP1_VALID   = 1'b0;
      RSP1_DATA    = '0;
      CM_CNT       = 2'd0;
      BUSY         = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant0 || grant1) begin
               REQ0_READY   = grant0;
               REQ1_READY   = grant1;
               st_d         = grant1 ? REQ1_DATA : REQ0_DATA;
               key_d        = grant1 ? REQ1_KEY  : REQ0_KEY;
               sel_d        = grant1 ? REQ1_SEL  : REQ0_SEL;
               owner_d      = grant1;
               last_grant_d = grant1;
               round_d      = '0;
               state_d      = RUN;
            end
         end
         RUN: begin
            BUSY   = 1'b1;
            CM_CNT = round_q[1:0];
            st_d   = CM_RESULT;
            // The round counter goes back to 0 after the last round, so it never goes past ROUNDS-1.
            if (round_q == LAST_ROUND) begin
               round_d = '0;
               state_d = RESP;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         RESP: begin
            BUSY = 1'b1;
            if (owner_q) begin
               RSP1_VALID = 1'b1;
               RSP1_DATA  = st_q;
            end else begin
               RSP0_VALID = 1'b1;
               RSP0_DATA  = st_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_crypto_seq_arbiter.sv
// Directed bench for crypto_seq_arbiter. A stub stands in for the crypto
// datapath: result = data + key + cnt. Instance "a" uses ROUNDS=4 and
// instance "b" uses ROUNDS=6.
module tb_crypto_seq_arbiter;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_pass = 0;
   int n_tot  = 0;

   // Instance a: ROUNDS = 4
   logic        RESET;
   logic        r0v, r0s, rdy0, rv0, r1v, r1s, rdy1, rv1;
   logic [31:0] r0d, r0k, rd0, r1d, r1k, rd1;
   logic [31:0] cm_din, cm_key, cm_res;
   logic [1:0]  cm_cnt;
   logic        cm_sel, busy;

   assign cm_res = cm_din + cm_key + {30'd0, cm_cnt};

   crypto_seq_arbiter #(.ROUNDS(4)) u_a (
      .CLK(CLK), .RESET(RESET),
      .REQ0_VALID(r0v), .REQ0_DATA(r0d), .REQ0_KEY(r0k), .REQ0_SEL(r0s),
      .REQ0_READY(rdy0), .RSP0_VALID(rv0), .RSP0_DATA(rd0),
      .REQ1_VALID(r1v), .REQ1_DATA(r1d), .REQ1_KEY(r1k), .REQ1_SEL(r1s),
      .REQ1_READY(rdy1), .RSP1_VALID(rv1), .RSP1_DATA(rd1),
      .CM_DATA_IN(cm_din), .CM_KEY(cm_key), .CM_CNT(cm_cnt), .CM_SEL(cm_sel),
      .CM_RESULT(cm_res), .BUSY(busy)
   );

   // Instance b: ROUNDS = 6
   logic        b_rst;
   logic        b_r0v, b_r0s, b_rdy0, b_rv0, b_r1v, b_r1s, b_rdy1, b_rv1;
   logic [31:0] b_r0d, b_r0k, b_rd0, b_r1d, b_r1k, b_rd1;
   logic [31:0] b_din, b_key, b_res;
   logic [1:0]  b_cnt;
   logic        b_sel, b_busy;

   assign b_res = b_din + b_key + {30'd0, b_cnt};

   crypto_seq_arbiter #(.ROUNDS(6)) u_b (
      .CLK(CLK), .RESET(b_rst),
      .REQ0_VALID(b_r0v), .REQ0_DATA(b_r0d), .REQ0_KEY(b_r0k), .REQ0_SEL(b_r0s),
      .REQ0_READY(b_rdy0), .RSP0_VALID(b_rv0), .RSP0_DATA(b_rd0),
      .REQ1_VALID(b_r1v), .REQ1_DATA(b_r1d), .REQ1_KEY(b_r1k), .REQ1_SEL(b_r1s),
      .REQ1_READY(b_rdy1), .RSP1_VALID(b_rv1), .RSP1_DATA(b_rd1),
      .CM_DATA_IN(b_din), .CM_KEY(b_key), .CM_CNT(b_cnt), .CM_SEL(b_sel),
      .CM_RESULT(b_res), .BUSY(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot = n_tot + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      RESET = 1'b1; b_rst = 1'b1;
      r0v = 0; r0d = '0; r0k = '0; r0s = 0;
      r1v = 0; r1d = '0; r1k = '0; r1s = 0;
      b_r0v = 0; b_r0d = '0; b_r0k = '0; b_r0s = 0;
      b_r1v = 0; b_r1d = '0; b_r1k = '0; b_r1s = 0;
      tick(2);

      // Reset state
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", {30'd0, rdy1, rdy0}, 32'd0);
      chk("rst_rspv", {30'd0, rv1, rv0}, 32'd0);
      chk("rst_cm_din", cm_din, 32'd0);
      chk("rst_cm_key", cm_key, 32'd0);
      chk("rst_cm_cnt_sel", {29'd0, cm_sel, cm_cnt}, 32'd0);
      RESET = 1'b0; b_rst = 1'b0;

      // 1: single port-0 job
      r0v = 1; r0d = 32'h10; r0k = 32'h1; r0s = 1;
      #1;
      chk("t1_ready0", 32'(rdy0), 32'd1);
      chk("t1_ready1", 32'(rdy1), 32'd0);
      tick(1);
      r0v = 0; r0d = 32'hFFFF; r0k = 32'h77; r0s = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t1_cnt", 32'(cm_cnt), 32'(i));
         chk("t1_sel", 32'(cm_sel), 32'd1);
         chk("t1_busy", 32'(busy), 32'd1);
         chk("t1_rspv_run", 32'(rv0), 32'd0);
         tick(1);
      end
      #1;
      chk("t1_rsp0_valid", 32'(rv0), 32'd1);
      chk("t1_rsp0_data", rd0, 32'h1A);
      chk("t1_rsp1_valid", 32'(rv1), 32'd0);
      chk("t1_rsp1_data", rd1, 32'd0);
      tick(1);
      #1;
      chk("t1_rsp0_after", 32'(rv0), 32'd0);
      chk("t1_rsp0_data_after", rd0, 32'd0);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_cnt_idle", 32'(cm_cnt), 32'd0);

      // 2 and 6: tie after reset, with port 1 holding its request
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      r0v = 1; r0d = 32'h10;  r0k = 32'h1; r0s = 0;
      r1v = 1; r1d = 32'h100; r1k = 32'h2; r1s = 0;
      #1;
      chk("t2_tie_ready0", 32'(rdy0), 32'd1);
      chk("t2_tie_ready1", 32'(rdy1), 32'd0);
      tick(1);
      r0v = 0;
      r1d = 32'hDEADBEEF;
      for (int i = 1; i < 5; i++) begin
         #1;
         chk("t6_hold_ready1_run", 32'(rdy1), 32'd0);
         tick(1);
      end
      #1;
      chk("t6_hold_ready1_resp", 32'(rdy1), 32'd0);
      chk("t2_rsp0_data", rd0, 32'h1A);
      chk("t2_rsp0_valid", 32'(rv0), 32'd1);
      tick(1);
      r1d = 32'h100;
      #1;
      chk("t2_grant1_ready1", 32'(rdy1), 32'd1);
      chk("t2_grant1_ready0", 32'(rdy0), 32'd0);
      tick(1);
      r1v = 0; r1d = 32'hFFFFFFFF; r1k = 32'h0;
      tick(4);
      #1;
      chk("t2_rsp1_valid", 32'(rv1), 32'd1);
      chk("t2_rsp1_data", rd1, 32'h10E);
      chk("t2_rsp0_quiet", {31'd0, rv0}, 32'd0);
      chk("t2_rsp0_data_quiet", rd0, 32'd0);
      tick(1);

      // 3: round-robin (port 1 was granted last)
      r1v = 1; r1d = 32'h5; r1k = 32'h0;
      #1;
      chk("t3_solo_ready1", 32'(rdy1), 32'd1);
      tick(1);
      r1v = 0;
      tick(5);
      r0v = 1; r1v = 1;
      #1;
      chk("t3_rr_ready0", 32'(rdy0), 32'd1);
      chk("t3_rr_ready1", 32'(rdy1), 32'd0);
      tick(1);
      r0v = 0;
      tick(5);
      r0v = 1;
      #1;
      chk("t3_rr2_ready1", 32'(rdy1), 32'd1);
      chk("t3_rr2_ready0", 32'(rdy0), 32'd0);
      tick(1);
      r0v = 0; r1v = 0;
      tick(5);

      // 4: reset during a port-0 job
      r0v = 1; r0d = 32'h10; r0k = 32'h1; r0s = 1;
      #1;
      chk("t4_ready0", 32'(rdy0), 32'd1);
      tick(1);
      r0v = 0;
      tick(1);
      RESET = 1'b1;
      tick(1);
      #1;
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_cm_din", cm_din, 32'd0);
      chk("t4_cm_key", cm_key, 32'd0);
      chk("t4_cm_cnt_sel", {29'd0, cm_sel, cm_cnt}, 32'd0);
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t4_no_rsp0", 32'(rv0), 32'd0);
         tick(1);
      end
      r0v = 1;
      #1;
      chk("t4_new_ready0", 32'(rdy0), 32'd1);
      tick(1);
      r0v = 0;
      tick(4);
      #1;
      chk("t4_new_rsp0_valid", 32'(rv0), 32'd1);
      chk("t4_new_rsp0_data", rd0, 32'h1A);
      tick(1);

      // 5: ROUNDS=6 build, CM_CNT wraps
      b_r0v = 1; b_r0d = 32'h0; b_r0k = 32'h0;
      #1;
      chk("t5_ready0", 32'(b_rdy0), 32'd1);
      tick(1);
      b_r0v = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("t5_cnt", 32'(b_cnt), 32'(i % 4));
         chk("t5_busy", 32'(b_busy), 32'd1);
         tick(1);
      end
      #1;
      chk("t5_rsp0_valid", 32'(b_rv0), 32'd1);
      chk("t5_rsp0_data", b_rd0, 32'd7);
      tick(1);
      #1;
      chk("t5_idle_busy", 32'(b_busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
